// File: rtl/food_spawn_controller_if.sv
// Occupancy query channel between the food spawner and the snake-body store.
// occ_req/occ_x/occ_y hold until occ_ack; occ_hit is meaningful only alongside occ_ack.
interface food_spawn_controller_if;
    logic       occ_req;
    logic [9:0] occ_x;
    logic [8:0] occ_y;
    logic       occ_ack;
    logic       occ_hit;

    modport master (output occ_req, occ_x, occ_y, input occ_ack, occ_hit);
    modport slave  (input occ_req, occ_x, occ_y, output occ_ack, occ_hit);
endinterface

// File: rtl/food_spawn_controller.sv
// Relocates the food cell after an eat/respawn, drawing grid-aligned random candidates
// and vetting each through an occupancy query; best case eat->spawned is 4 cycles, waits on occ_ack forever.
module food_spawn_controller #(
    parameter int X_MIN     = 10,
    parameter int X_MAX     = 620,
    parameter int Y_MIN     = 10,
    parameter int Y_MAX     = 460,
    parameter int GRID      = 10,
    parameter int INIT_X    = 320,
    parameter int INIT_Y    = 240,
    parameter int MAX_TRIES = 15
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    input  logic [9:0]                head_x,
    input  logic [8:0]                head_y,
    input  logic                      head_valid,
    input  logic                      respawn,
    input  logic [9:0]                rand_x,
    input  logic [8:0]                rand_y,
    food_spawn_controller_if.master   occ,
    output logic [9:0]                food_x,
    output logic [8:0]                food_y,
    output logic                      food_valid,
    output logic                      eaten,
    output logic                      spawned,
    output logic                      fail,
    output logic                      busy
);
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, QUERY, COMMIT} stateT;

    stateT         state, stateNext;
    logic [TW-1:0] tries, triesNext, triesInc;
    logic [9:0]    candX, candXNext, foodXNext;
    logic [8:0]    candY, candYNext, foodYNext;
    logic          occReq, occReqNext;
    logic          foodValidNext, eatenNext, spawnedNext, failNext, busyNext;
    logic          eatMatch, candLegal, bumpTries, triesWrap;

    assign eatMatch  = head_valid && food_valid && (head_x == food_x) && (head_y == food_y);
    assign candLegal = (int'(rand_x) >= X_MIN) && (int'(rand_x) <= X_MAX) &&
                       (int'(rand_y) >= Y_MIN) && (int'(rand_y) <= Y_MAX) &&
                       ((int'(rand_x) % GRID) == 0) && ((int'(rand_y) % GRID) == 0);
    assign triesInc  = tries + 1'b1;
    assign triesWrap = (int'(triesInc) == MAX_TRIES);

    always_comb begin
        stateNext     = state;
        triesNext     = tries;
        candXNext     = candX;
        candYNext     = candY;
        occReqNext    = occReq;
        foodXNext     = food_x;
        foodYNext     = food_y;
        foodValidNext = food_valid;
        eatenNext     = 1'b0;
        spawnedNext   = 1'b0;
        failNext      = 1'b0;
        bumpTries     = 1'b0;

        case (state)
            IDLE: begin
                if (eatMatch || respawn) begin
                    eatenNext     = eatMatch;
                    foodValidNext = 1'b0;
                    triesNext     = '0;
                    stateNext     = SAMPLE;
                end
            end
            SAMPLE: begin
                if (candLegal) begin
                    candXNext  = rand_x;
                    candYNext  = rand_y;
                    occReqNext = 1'b1;
                    stateNext  = QUERY;
                end else begin
                    bumpTries = 1'b1;
                end
            end
            QUERY: begin
                if (occ.occ_ack) begin
                    occReqNext = 1'b0;
                    if (occ.occ_hit) begin
                        bumpTries = 1'b1;
                        stateNext = SAMPLE;
                    end else begin
                        stateNext = COMMIT;
                    end
                end
            end
            COMMIT: begin
                foodXNext     = candX;
                foodYNext     = candY;
                foodValidNext = 1'b1;
                spawnedNext   = 1'b1;
                stateNext     = IDLE;
            end
            default: stateNext = IDLE;
        endcase

        // A fail only reports exhaustion; the search carries on with a fresh count.
        if (bumpTries) begin
            if (triesWrap) begin
                failNext  = 1'b1;
                triesNext = '0;
            end else begin
                triesNext = triesInc;
            end
        end

        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            tries      <= '0;
            candX      <= '0;
            candY      <= '0;
            occReq     <= 1'b0;
            food_x     <= 10'(INIT_X);
            food_y     <= 9'(INIT_Y);
            food_valid <= 1'b1;
            eaten      <= 1'b0;
            spawned    <= 1'b0;
            fail       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= stateNext;
            tries      <= triesNext;
            candX      <= candXNext;
            candY      <= candYNext;
            occReq     <= occReqNext;
            food_x     <= foodXNext;
            food_y     <= foodYNext;
            food_valid <= foodValidNext;
            eaten      <= eatenNext;
            spawned    <= spawnedNext;
            fail       <= failNext;
            busy       <= busyNext;
        end
    end

    // The latched candidate doubles as the query address, so it stays put until ack.
    assign occ.occ_req = occReq;
    assign occ.occ_x   = candX;
    assign occ.occ_y   = candY;
endmodule

// File: tb/tb_food_spawn_controller.sv
// Random relocation traffic against a transaction-level model of the food spawner;
// candidates, occupancy answers and ack delays come from directed queues or $urandom.
module tb_food_spawn_controller;
    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b1;
    logic [9:0] head_x, rand_x, food_x;
    logic [8:0] head_y, rand_y, food_y;
    logic       head_valid, respawn, food_valid, eaten, spawned, fail, busy;

    int total = 0;
    int bad   = 0;
    int expFoodX = 320;
    int expFoodY = 240;
    int qx[$], qy[$], qd[$];
    bit qh[$];

    food_spawn_controller_if occ ();

    food_spawn_controller dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .head_x     (head_x),
        .head_y     (head_y),
        .head_valid (head_valid),
        .respawn    (respawn),
        .rand_x     (rand_x),
        .rand_y     (rand_y),
        .occ        (occ),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .eaten      (eaten),
        .spawned    (spawned),
        .fail       (fail),
        .busy       (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic checkEq(input string tag, input int obs, input int want);
        total++;
        if (obs != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    function automatic bit legal(input int x, input int y);
        return (x >= 10) && (x <= 620) && (y >= 10) && (y <= 460) &&
               (x % 10 == 0) && (y % 10 == 0);
    endfunction

    task automatic push(input int x, input int y, input bit hit, input int dly);
        qx.push_back(x); qy.push_back(y); qh.push_back(hit); qd.push_back(dly);
    endtask

    task automatic pickCand(output int x, output int y, output bit hit, output int dly);
        if (qx.size() > 0) begin
            x = qx.pop_front(); y = qy.pop_front(); hit = qh.pop_front(); dly = qd.pop_front();
        end else begin
            if ($urandom_range(0, 1) == 1) begin
                x = 10 * int'($urandom_range(1, 62));
                y = 10 * int'($urandom_range(1, 46));
            end else begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 511));
            end
            hit = ($urandom_range(0, 9) < 4);
            dly = int'($urandom_range(0, 3));
        end
    endtask

    // While busy, eat/respawn requests and the random source must all be ignored.
    task automatic noise();
        head_x     = 10'(expFoodX);
        head_y     = 9'(expFoodY);
        head_valid = 1'($urandom_range(0, 1));
        respawn    = 1'($urandom_range(0, 1));
        rand_x     = 10'($urandom_range(0, 1023));
        rand_y     = 9'($urandom_range(0, 511));
    endtask

    task automatic step(inout int cyc);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        cyc++;
    endtask

    task automatic bump(inout int tries);
        tries++;
        if (tries == 15) begin
            checkEq("fail_pulse", fail, 1);
            tries = 0;
        end else begin
            checkEq("fail_quiet", fail, 0);
        end
    endtask

    // One full relocation; lat counts edges after the trigger edge up to the commit edge.
    task automatic relocate(input bit eat, input bit resp, output int lat);
        int x, y, dly, tries, cyc;
        bit hit, done;
        lat = -1; tries = 0; cyc = 0; done = 0;
        head_x = 10'(expFoodX); head_y = 9'(expFoodY);
        head_valid = eat; respawn = resp;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        head_valid = 0; respawn = 0;
        checkEq("eaten", eaten, int'(eat));
        checkEq("fv_low", food_valid, 0);
        checkEq("busy_hi", busy, 1);
        while (!done && cyc < 500) begin
            pickCand(x, y, hit, dly);
            noise();
            rand_x = 10'(x); rand_y = 9'(y);
            step(cyc);
            checkEq("eaten_quiet", eaten, 0);
            if (!legal(x, y)) begin
                checkEq("rej_no_req", occ.occ_req, 0);
                bump(tries);
            end else begin
                checkEq("req", occ.occ_req, 1);
                checkEq("occ_x", occ.occ_x, x);
                checkEq("occ_y", occ.occ_y, y);
                repeat (dly) begin
                    noise();
                    step(cyc);
                    checkEq("req_hold", occ.occ_req, 1);
                    checkEq("occ_x_hold", occ.occ_x, x);
                    checkEq("occ_y_hold", occ.occ_y, y);
                end
                noise();
                occ.occ_ack = 1; occ.occ_hit = hit;
                step(cyc);
                occ.occ_ack = 0; occ.occ_hit = 1'($urandom_range(0, 1));
                checkEq("req_drop", occ.occ_req, 0);
                if (hit) begin
                    bump(tries);
                end else begin
                    checkEq("fail_commit", fail, 0);
                    checkEq("busy_commit", busy, 1);
                    checkEq("fv_commit", food_valid, 0);
                    noise();
                    step(cyc);
                    head_valid = 0; respawn = 0;
                    checkEq("spawned", spawned, 1);
                    checkEq("food_x", food_x, x);
                    checkEq("food_y", food_y, y);
                    checkEq("fv_hi", food_valid, 1);
                    checkEq("busy_lo", busy, 0);
                    expFoodX = x; expFoodY = y;
                    lat = cyc; done = 1;
                end
            end
        end
        checkEq("reloc_done", int'(done), 1);
        head_valid = 0; respawn = 0;
        step(cyc);
        checkEq("spawned_pulse", spawned, 0);
        checkEq("idle_busy", busy, 0);
    endtask

    initial begin
        int lat, cyc;
        bit e;
        head_x = 0; head_y = 0; head_valid = 0; respawn = 0; rand_x = 0; rand_y = 0;
        occ.occ_ack = 0; occ.occ_hit = 0;
        #2 resetn = 0;
        #3;
        checkEq("rst_food_x", food_x, 320);
        checkEq("rst_food_y", food_y, 240);
        checkEq("rst_fv", food_valid, 1);
        checkEq("rst_req", occ.occ_req, 0);
        checkEq("rst_occ_x", occ.occ_x, 0);
        checkEq("rst_occ_y", occ.occ_y, 0);
        checkEq("rst_pulses", {29'd0, eaten, spawned, fail}, 0);
        checkEq("rst_busy", busy, 0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1;
        @(negedge CLOCK_50);

        // head next to, not on, the food: nothing happens
        head_x = 330; head_y = 240; head_valid = 1;
        cyc = 0;
        step(cyc);
        head_valid = 0;
        checkEq("miss_eaten", eaten, 0);
        checkEq("miss_busy", busy, 0);

        // best case: trigger edge N, commit edge N+3 -> spawned seen in cycle N+4
        push(150, 200, 0, 0);
        relocate(1, 0, lat);
        checkEq("best_latency", lat, 3);

        push(155, 200, 0, 0); push(630, 200, 0, 0); push(40, 50, 0, 0);
        relocate(0, 1, lat);

        for (int i = 0; i < 15; i++)
            push(10 * int'($urandom_range(1, 62)), 10 * int'($urandom_range(1, 46)), 1,
                 int'($urandom_range(0, 1)));
        push(70, 80, 0, 0);
        relocate(1, 1, lat);

        push(200, 100, 0, 5);
        relocate(1, 0, lat);

        push(200, 100, 0, 0);
        relocate(0, 1, lat);

        repeat (25) begin
            e = 1'($urandom_range(0, 1));
            relocate(e, !e || ($urandom_range(0, 1) == 1), lat);
        end

        // reset while a query is outstanding
        head_x = 10'(expFoodX); head_y = 9'(expFoodY); head_valid = 1;
        rand_x = 300; rand_y = 300;
        step(cyc);
        head_valid = 0;
        step(cyc);
        checkEq("pre_rst_req", occ.occ_req, 1);
        #2 resetn = 0;
        #1;
        checkEq("mid_rst_req", occ.occ_req, 0);
        checkEq("mid_rst_food_x", food_x, 320);
        checkEq("mid_rst_food_y", food_y, 240);
        checkEq("mid_rst_fv", food_valid, 1);
        checkEq("mid_rst_busy", busy, 0);
        @(negedge CLOCK_50);
        resetn = 1;
        occ.occ_ack = 1; occ.occ_hit = 0;
        step(cyc);
        occ.occ_ack = 0;
        checkEq("late_ack_busy", busy, 0);
        checkEq("late_ack_req", occ.occ_req, 0);
        step(cyc);
        checkEq("late_ack_spawned", spawned, 0);
        checkEq("late_ack_food_x", food_x, 320);
        checkEq("late_ack_fv", food_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/food_spawn_controller.md
FOOD_SPAWN_CONTROLLER -- requirements
Module: food_spawn_controller

Interface
REQ-001 Parameter X_MIN, default 10, lowest legal food x (pixels).
REQ-002 Parameter X_MAX, default 620, highest legal food x.
REQ-003 Parameter Y_MIN, default 10, lowest legal food y.
REQ-004 Parameter Y_MAX, default 460, highest legal food y.
REQ-005 Parameter GRID, default 10, cell pitch; legal coordinates are multiples of GRID.
REQ-006 Parameter INIT_X/INIT_Y, default 320/240, food position after reset.
REQ-007 Parameter MAX_TRIES, default 15, rejected candidates before a fail pulse.
REQ-008 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-009 resetn  in  1  asynchronous, active-low reset.
REQ-010 head_x  in  10  snake head x; head_y  in  9  snake head y.
REQ-011 head_valid  in  1  one-cycle pulse; head_x/head_y hold a new head position.
REQ-012 respawn  in  1  one-cycle pulse requesting relocation without an eat event.
REQ-013 rand_x  in  10, rand_y  in  9  free-running random generator outputs.
REQ-014 occ_req  out  1, occ_x  out  10, occ_y  out  9  occupancy query to the snake-body store.
REQ-015 occ_ack  in  1, occ_hit  in  1  query completion; occ_hit is valid only when occ_ack=1.
REQ-016 food_x  out  10, food_y  out  9, food_valid  out  1  current food cell.
REQ-017 eaten  out  1, spawned  out  1, fail  out  1  one-cycle status pulses; busy  out  1  high when state is not IDLE.

Function
REQ-018 States: IDLE, SAMPLE, QUERY, COMMIT; all outputs are registered.
REQ-019 IDLE: head_valid=1, food_valid=1, head_x==food_x, head_y==food_y -> eaten=1 next cycle, food_valid<=0, tries<=0, go SAMPLE.
REQ-020 IDLE: respawn=1 (no eat match) -> same as REQ-019 but eaten stays 0; an eat match and respawn together give one relocation with eaten=1.
REQ-021 head_valid and respawn are ignored outside IDLE.
REQ-022 SAMPLE: rand_x/rand_y are sampled at the edge; a candidate is legal if X_MIN<=x<=X_MAX, Y_MIN<=y<=Y_MAX, x%GRID==0, y%GRID==0.
REQ-023 SAMPLE, legal candidate: latch into cand_x/cand_y, go QUERY.
REQ-024 SAMPLE, illegal candidate: tries<=tries+1, stay SAMPLE.
REQ-025 QUERY: occ_req=1 with occ_x/occ_y=cand; both held stable until the cycle occ_ack=1; occ_req drops the cycle after ack.
REQ-026 QUERY with occ_ack=1: occ_hit=0 -> COMMIT; occ_hit=1 -> tries<=tries+1, go SAMPLE.
REQ-027 When an increment would make tries equal MAX_TRIES: fail=1 for one cycle, tries<=0, and sampling continues; fail does not commit anything.
REQ-028 COMMIT: food_x/food_y<=cand, food_valid<=1, spawned=1 for one cycle, go IDLE.
REQ-029 Best-case latency: eat edge N -> eaten high in N+1, occ_req high in N+2 -> with same-cycle ack, spawned high and food_valid=1 in N+4.
REQ-030 No timeout on occ_ack; QUERY waits indefinitely.
REQ-031 A candidate equal to the old food cell is legal unless occupancy reports a hit.

Reset
REQ-032 resetn=0 immediately forces: state IDLE, food_x=INIT_X, food_y=INIT_Y, food_valid=1, occ_req=0, occ_x=0, occ_y=0, eaten=spawned=fail=0, busy=0, tries=0.
REQ-033 Reset during QUERY drops occ_req without waiting for ack; a later occ_ack in IDLE is ignored.

Verification
REQ-034 Reset, head_valid at (320,240) -> eaten pulse, food_valid low, busy high.
REQ-035 Eat with rand=(150,200), occ_ack same cycle, occ_hit=0 -> occ_x/occ_y=150/200; spawned in N+4; food=(150,200).
REQ-036 rand=(155,200), then (630,200), then (40,50) -> two rejections, one query at (40,50), commit (40,50).
REQ-037 occ_hit=1 for 15 consecutive legal candidates -> fail pulse on the 15th; then occ_hit=0 -> commit.
REQ-038 occ_ack delayed 5 cycles -> occ_req and occ_x/occ_y stable for all 5 cycles; head_valid at the food cell during this wait is ignored.
REQ-039 resetn low mid-QUERY -> occ_req=0 at once; food=(320,240), food_valid=1; a late ack causes no state change.
